// File: rtl/pc_btb.sv
// pc_btb: fetch-stage program counter with a direct-mapped branch target
// buffer (BTB) and 2-bit saturating direction counters.
//
// The fetch PC is registered. The prediction for the current fetch PC and the
// address loaded at the next edge are combinational from the PC, the table
// state and the inputs. Resolved control-flow instructions train the table;
// the resolve stage can redirect fetch at any time.
//
// Optional feature macro: PC_BTB_RAS_EN
//   defined   : RAS_DEPTH-entry circular return-address stack. Calls that hit
//               push PC+4 and returns that hit predict (and pop) the stack top.
//               RAS_DEPTH must be a power of two, at least 2.
//   undefined : no stack; calls and returns use the stored BTB target.
//
// Parameters
//   PC_INIT      fetch PC loaded on reset
//   BTB_ENTRIES  number of BTB entries (power of two, >= 2)
//   RAS_DEPTH    return-address-stack depth (PC_BTB_RAS_EN builds only)
//
// Ports
//   CLK            in   clock, rising edge
//   nRST           in   asynchronous active-low reset
//   pc_wait        in   hold the fetch PC
//   redirect       in   load redirect_addr (overrides pc_wait)
//   redirect_addr  in   corrected fetch address
//   upd_valid      in   resolved control-flow instruction this cycle
//   upd_pc         in   address of the resolved instruction
//   upd_target     in   resolved target
//   upd_taken      in   resolved direction
//   upd_type       in   00 branch, 01 jump, 10 call, 11 return
//   imemaddr       out  current fetch PC
//   next_imemaddr  out  PC loaded at the next edge
//   pred_taken     out  current fetch PC predicted taken
//   pred_target    out  predicted target, or imemaddr+4 when not taken
module pc_btb #(
  parameter logic [31:0] PC_INIT     = 32'd0,
  parameter int          BTB_ENTRIES = 16,
  parameter int          RAS_DEPTH   = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        pc_wait,
  input  logic        redirect,
  input  logic [31:0] redirect_addr,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic [31:0] upd_target,
  input  logic        upd_taken,
  input  logic [1:0]  upd_type,
  output logic [31:0] imemaddr,
  output logic [31:0] next_imemaddr,
  output logic        pred_taken,
  output logic [31:0] pred_target
);

  localparam int IDX   = $clog2(BTB_ENTRIES);
  localparam int TAG_W = 32 - IDX - 2;

  localparam logic [1:0] TYPE_BR   = 2'b00;
  localparam logic [1:0] TYPE_CALL = 2'b10;
  localparam logic [1:0] TYPE_RET  = 2'b11;

  function automatic logic [1:0] ctr_sat_inc(input logic [1:0] c);
    return (c == 2'b11) ? 2'b11 : c + 2'b01;
  endfunction

  function automatic logic [1:0] ctr_sat_dec(input logic [1:0] c);
    return (c == 2'b00) ? 2'b00 : c - 2'b01;
  endfunction

  logic [BTB_ENTRIES-1:0] btb_valid;
  logic [1:0]             btb_ctr    [BTB_ENTRIES];
  logic [TAG_W-1:0]       btb_tag    [BTB_ENTRIES];
  logic [31:0]            btb_target [BTB_ENTRIES];
  logic [1:0]             btb_type   [BTB_ENTRIES];

  // Fetch-side lookup
  logic [IDX-1:0]   f_idx;
  logic [TAG_W-1:0] f_tag;
  logic             f_hit;
  logic [1:0]       f_type;
  logic [31:0]      pc_plus4;
  logic [31:0]      hit_target;
  logic             advance;

  assign f_idx    = imemaddr[IDX+1:2];
  assign f_tag    = imemaddr[31:IDX+2];
  assign f_hit    = btb_valid[f_idx] && (btb_tag[f_idx] == f_tag);
  assign f_type   = btb_type[f_idx];
  assign pc_plus4 = imemaddr + 32'd4;
  assign advance  = !pc_wait && !redirect;

  // Jumps, calls and returns are always taken; branches follow the counter MSB.
  assign pred_taken  = f_hit && ((f_type != TYPE_BR) || btb_ctr[f_idx][1]);
  assign pred_target = pred_taken ? hit_target : pc_plus4;

`ifdef PC_BTB_RAS_EN
  localparam int             RAS_W    = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam logic [RAS_W:0] RAS_FULL = (RAS_W + 1)'(RAS_DEPTH);

  logic [31:0]      ras_stack [RAS_DEPTH];
  logic [RAS_W-1:0] ras_ptr;
  logic [RAS_W:0]   ras_cnt;
  logic [RAS_W-1:0] ras_top_ptr;
  logic             ras_push;
  logic             ras_pop;

  // ras_ptr is the next slot to write; the top of stack sits just below it.
  assign ras_top_ptr = ras_ptr - RAS_W'(1);
  assign ras_push    = advance && f_hit && (f_type == TYPE_CALL);
  assign ras_pop     = advance && f_hit && (f_type == TYPE_RET) && (ras_cnt != '0);
  assign hit_target  = ((f_type == TYPE_RET) && (ras_cnt != '0)) ?
                       ras_stack[ras_top_ptr] : btb_target[f_idx];

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ras_ptr <= '0;
      ras_cnt <= '0;
    end else if (ras_push) begin
      // A full stack keeps wrapping over its oldest entry.
      ras_ptr <= ras_ptr + RAS_W'(1);
      if (ras_cnt != RAS_FULL) ras_cnt <= ras_cnt + 1'b1;
    end else if (ras_pop) begin
      ras_ptr <= ras_top_ptr;
      ras_cnt <= ras_cnt - 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (ras_push) ras_stack[ras_ptr] <= pc_plus4;
  end
`else
  localparam int unused_ras_depth = RAS_DEPTH;
  assign hit_target = btb_target[f_idx];
`endif

  // Next-PC selection
  always_comb begin
    next_imemaddr = pc_plus4;
    if (redirect)        next_imemaddr = redirect_addr;
    else if (pc_wait)    next_imemaddr = imemaddr;
    else if (pred_taken) next_imemaddr = pred_target;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) imemaddr <= PC_INIT;
    else       imemaddr <= next_imemaddr;
  end

  // Training from the resolve stage
  logic [IDX-1:0]   u_idx;
  logic [TAG_W-1:0] u_tag;
  logic             u_hit;
  logic             unused_upd_bits;

  assign u_idx           = upd_pc[IDX+1:2];
  assign u_tag           = upd_pc[31:IDX+2];
  assign u_hit           = btb_valid[u_idx] && (btb_tag[u_idx] == u_tag);
  assign unused_upd_bits = ^upd_pc[1:0];

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      btb_valid <= '0;
      for (int i = 0; i < BTB_ENTRIES; i++) btb_ctr[i] <= 2'b01;
    end else if (upd_valid) begin
      if (u_hit) begin
        btb_ctr[u_idx] <= upd_taken ? ctr_sat_inc(btb_ctr[u_idx])
                                    : ctr_sat_dec(btb_ctr[u_idx]);
      end else if (upd_taken) begin
        btb_valid[u_idx] <= 1'b1;
        btb_ctr[u_idx]   <= 2'b10;
      end
    end
  end

  // Payload fields: a taken update either refreshes a hit or allocates over
  // the occupant, and both cases write the same fields. Entries are only
  // trusted once valid, so the payload needs no reset.
  always_ff @(posedge CLK) begin
    if (upd_valid && upd_taken) begin
      btb_tag[u_idx]    <= u_tag;
      btb_target[u_idx] <= upd_target;
      btb_type[u_idx]   <= upd_type;
    end
  end

endmodule

// File: tb/tb_pc_btb.sv
module tb_pc_btb;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        pc_wait;
  logic        redirect;
  logic [31:0] redirect_addr;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic        upd_taken;
  logic [1:0]  upd_type;
  logic [31:0] imemaddr;
  logic [31:0] next_imemaddr;
  logic        pred_taken;
  logic [31:0] pred_target;

  pc_btb #(
    .PC_INIT    (32'h100),
    .BTB_ENTRIES(16),
    .RAS_DEPTH  (4)
  ) dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .pc_wait      (pc_wait),
    .redirect     (redirect),
    .redirect_addr(redirect_addr),
    .upd_valid    (upd_valid),
    .upd_pc       (upd_pc),
    .upd_target   (upd_target),
    .upd_taken    (upd_taken),
    .upd_type     (upd_type),
    .imemaddr     (imemaddr),
    .next_imemaddr(next_imemaddr),
    .pred_taken   (pred_taken),
    .pred_target  (pred_target)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int          cyc;
    string       name;
    logic [31:0] pc;
    logic        pt;
    logic [31:0] tgt;
    logic [31:0] nxt;
  } exp_t;

  exp_t sb[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  always @(posedge CLK) cyc++;

  task automatic cmp(input string name, input string field,
                     input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s.%s got=%h want=%h (cycle %0d)", name, field, act, want, cyc);
    end
  endtask

  // Monitor: each cycle, pop every expectation that belongs to this cycle.
  always @(negedge CLK) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      if (e.cyc < cyc) begin
        total++;
        bad++;
        $display("FAIL %s missed got=none want=cycle%0d", e.name, e.cyc);
      end else begin
        cmp(e.name, "imemaddr", imemaddr, e.pc);
        cmp(e.name, "pred_taken", {31'd0, pred_taken}, {31'd0, e.pt});
        cmp(e.name, "pred_target", pred_target, e.tgt);
        cmp(e.name, "next_imemaddr", next_imemaddr, e.nxt);
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic w, input logic r, input logic [31:0] ra,
                       input logic uv, input logic [31:0] up, input logic [31:0] ut,
                       input logic utk, input logic [1:0] uty);
    pc_wait       = w;
    redirect      = r;
    redirect_addr = ra;
    upd_valid     = uv;
    upd_pc        = up;
    upd_target    = ut;
    upd_taken     = utk;
    upd_type      = uty;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 2'b00);
  endtask

  task automatic exp_push(input string name, input logic [31:0] pc, input logic pt,
                          input logic [31:0] tgt, input logic [31:0] nxt);
    exp_t e;
    e.cyc  = cyc;
    e.name = name;
    e.pc   = pc;
    e.pt   = pt;
    e.tgt  = tgt;
    e.nxt  = nxt;
    sb.push_back(e);
  endtask

  initial begin
    nRST = 1'b0;
    idle();
    repeat (2) tick();
    exp_push("in_reset", 32'h100, 1'b0, 32'h104, 32'h104);

    // Sequential fetch out of reset
    tick(); nRST = 1'b1;
    exp_push("seq0", 32'h100, 1'b0, 32'h104, 32'h104);
    tick(); exp_push("seq1", 32'h104, 1'b0, 32'h108, 32'h108);
    tick(); exp_push("seq2", 32'h108, 1'b0, 32'h10C, 32'h10C);

    // Stall, then redirect while stalled
    tick(); drive(0, 1, 32'h20, 0, 0, 0, 0, 2'b00);
    exp_push("redir20", 32'h10C, 1'b0, 32'h110, 32'h20);
    for (int i = 0; i < 3; i++) begin
      tick(); drive(1, 0, 0, 0, 0, 0, 0, 2'b00);
      exp_push("wait20", 32'h20, 1'b0, 32'h24, 32'h20);
    end
    tick(); drive(1, 1, 32'h400, 0, 0, 0, 0, 2'b00);
    exp_push("wait_redir", 32'h20, 1'b0, 32'h24, 32'h400);

    // Allocate branch at 0x40 -> 0x80 and walk its counter
    tick(); drive(1, 0, 0, 1, 32'h40, 32'h80, 1, 2'b00);
    exp_push("alloc40", 32'h400, 1'b0, 32'h404, 32'h400);
    tick(); drive(0, 1, 32'h40, 0, 0, 0, 0, 2'b00);
    exp_push("to40", 32'h400, 1'b0, 32'h404, 32'h40);
    tick(); drive(1, 0, 0, 1, 32'h40, 32'h80, 0, 2'b00);
    exp_push("ctr10_rbw", 32'h40, 1'b1, 32'h80, 32'h40);
    tick(); drive(1, 0, 0, 1, 32'h40, 32'h80, 0, 2'b00);
    exp_push("ctr01", 32'h40, 1'b0, 32'h44, 32'h40);
    tick(); idle();
    exp_push("ctr00", 32'h40, 1'b0, 32'h44, 32'h44);
    for (int i = 0; i < 3; i++) begin
      tick(); drive(1, 0, 0, 1, 32'h40, 32'h80, 1, 2'b00);
      exp_push("train_up", 32'h44, 1'b0, 32'h48, 32'h44);
    end
    // Counter should be saturated at 11: one not-taken leaves it taken
    tick(); drive(1, 1, 32'h40, 1, 32'h40, 32'h80, 0, 2'b00);
    exp_push("redir_and_upd", 32'h44, 1'b0, 32'h48, 32'h40);
    tick(); drive(1, 0, 0, 1, 32'h40, 32'h80, 0, 2'b00);
    exp_push("sat_ctr10", 32'h40, 1'b1, 32'h80, 32'h40);
    tick(); drive(1, 0, 0, 0, 0, 0, 0, 2'b00);
    exp_push("sat_ctr01", 32'h40, 1'b0, 32'h44, 32'h40);

    // Alias: 0x80 shares the index of 0x40 and evicts it
    tick(); drive(1, 0, 0, 1, 32'h80, 32'h200, 1, 2'b01);
    exp_push("alloc80", 32'h40, 1'b0, 32'h44, 32'h40);
    tick(); drive(1, 1, 32'h80, 0, 0, 0, 0, 2'b00);
    exp_push("alias40_miss", 32'h40, 1'b0, 32'h44, 32'h80);
    tick(); idle();
    exp_push("alias80_hit", 32'h80, 1'b1, 32'h200, 32'h200);

    // 32-bit wrap
    tick(); drive(0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0, 2'b00);
    exp_push("to_top", 32'h200, 1'b0, 32'h204, 32'hFFFF_FFFC);
    tick(); idle();
    exp_push("wrap", 32'hFFFF_FFFC, 1'b0, 32'h0, 32'h0);
    tick(); idle();
    exp_push("wrapped", 32'h0, 1'b0, 32'h4, 32'h4);

    // Asynchronous reset during an update discards the update and the table
    tick(); drive(0, 0, 0, 1, 32'h8, 32'h300, 1, 2'b00); nRST = 1'b0;
    exp_push("reset_mid_upd", 32'h100, 1'b0, 32'h104, 32'h104);
    tick(); nRST = 1'b1; drive(0, 1, 32'h8, 0, 0, 0, 0, 2'b00);
    exp_push("post_reset", 32'h100, 1'b0, 32'h104, 32'h8);
    tick(); drive(0, 1, 32'h80, 0, 0, 0, 0, 2'b00);
    exp_push("upd_discarded", 32'h8, 1'b0, 32'hC, 32'h80);
    tick(); drive(1, 0, 0, 1, 32'h10, 32'h20, 1, 2'b10);
    exp_push("table_cleared", 32'h80, 1'b0, 32'h84, 32'h80);

`ifdef PC_BTB_RAS_EN
    // Nested calls 10->20->30->40->50->60, return at 0x64 (stored target 0x700)
    tick(); drive(1, 0, 0, 1, 32'h20, 32'h30, 1, 2'b10);
    exp_push("train_call", 32'h80, 1'b0, 32'h84, 32'h80);
    tick(); drive(1, 0, 0, 1, 32'h30, 32'h40, 1, 2'b10);
    exp_push("train_call", 32'h80, 1'b0, 32'h84, 32'h80);
    tick(); drive(1, 0, 0, 1, 32'h40, 32'h50, 1, 2'b10);
    exp_push("train_call", 32'h80, 1'b0, 32'h84, 32'h80);
    tick(); drive(1, 0, 0, 1, 32'h64, 32'h700, 1, 2'b11);
    exp_push("train_ret", 32'h80, 1'b0, 32'h84, 32'h80);
    tick(); drive(0, 1, 32'h10, 0, 0, 0, 0, 2'b00);
    exp_push("to_call10", 32'h80, 1'b0, 32'h84, 32'h10);
    tick(); idle(); exp_push("call10", 32'h10, 1'b1, 32'h20, 32'h20);
    tick(); idle(); exp_push("call20", 32'h20, 1'b1, 32'h30, 32'h30);
    tick(); idle(); exp_push("call30", 32'h30, 1'b1, 32'h40, 32'h40);
    tick(); drive(0, 0, 0, 1, 32'h50, 32'h60, 1, 2'b10);
    exp_push("call40", 32'h40, 1'b1, 32'h50, 32'h50);
    tick(); idle(); exp_push("call50", 32'h50, 1'b1, 32'h60, 32'h60);
    tick(); idle(); exp_push("seq60", 32'h60, 1'b0, 32'h64, 32'h64);
    tick(); idle(); exp_push("ret_54", 32'h64, 1'b1, 32'h54, 32'h54);
    tick(); drive(0, 1, 32'h64, 0, 0, 0, 0, 2'b00);
    exp_push("at54", 32'h54, 1'b0, 32'h58, 32'h64);
    tick(); idle(); exp_push("ret_44", 32'h64, 1'b1, 32'h44, 32'h44);
    tick(); drive(0, 1, 32'h64, 0, 0, 0, 0, 2'b00);
    exp_push("at44", 32'h44, 1'b0, 32'h48, 32'h64);
    tick(); idle(); exp_push("ret_34", 32'h64, 1'b1, 32'h34, 32'h34);
    tick(); drive(0, 1, 32'h64, 0, 0, 0, 0, 2'b00);
    exp_push("at34", 32'h34, 1'b0, 32'h38, 32'h64);
    tick(); idle(); exp_push("ret_24", 32'h64, 1'b1, 32'h24, 32'h24);
    tick(); drive(0, 1, 32'h64, 0, 0, 0, 0, 2'b00);
    exp_push("at24", 32'h24, 1'b0, 32'h28, 32'h64);
    tick(); idle(); exp_push("ret_empty", 32'h64, 1'b1, 32'h700, 32'h700);
    tick(); idle(); exp_push("at700", 32'h700, 1'b0, 32'h704, 32'h704);
`else
    // Without a stack, a return predicts its stored BTB target
    tick(); drive(1, 0, 0, 1, 32'h64, 32'h700, 1, 2'b11);
    exp_push("train_ret", 32'h80, 1'b0, 32'h84, 32'h80);
    tick(); drive(0, 1, 32'h64, 0, 0, 0, 0, 2'b00);
    exp_push("to_ret", 32'h80, 1'b0, 32'h84, 32'h64);
    tick(); idle(); exp_push("ret_btb", 32'h64, 1'b1, 32'h700, 32'h700);
    tick(); idle(); exp_push("at700", 32'h700, 1'b0, 32'h704, 32'h704);
`endif

    tick(); idle();
    repeat (2) @(negedge CLK);
    #1;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_btb.md
# pc_btb

Parametrised program-counter unit for the fetch stage, successor to the single-source PC. Holds the fetch PC, predicts the next fetch address each cycle from a direct-mapped branch target buffer (BTB) with 2-bit saturating counters, accepts redirects from the resolve stage, and trains the BTB from resolved control-flow instructions. Drives the instruction-memory address and exposes the prediction so downstream stages can detect mispredicts.

## Interface
- PC_INIT, 32'd0, fetch PC loaded on reset
- BTB_ENTRIES, 16, number of BTB entries; power of two, at least 2; IDX = log2(BTB_ENTRIES)
- RAS_DEPTH, 4, return-address-stack depth; power of two; used only with PC_BTB_RAS_EN
- CLK  in  1  clock, rising edge
- nRST  in  1  reset, asynchronous, active-low
- pc_wait  in  1  hold the fetch PC (memory not ready / hazard stall)
- redirect  in  1  mispredict or exception; load redirect_addr
- redirect_addr  in  32  corrected fetch address
- upd_valid  in  1  resolved control-flow instruction this cycle
- upd_pc  in  32  address of the resolved instruction
- upd_target  in  32  resolved target
- upd_taken  in  1  resolved direction
- upd_type  in  2  00 conditional branch, 01 jump, 10 call (jal), 11 return (jr $ra)
- imemaddr  out  32  current fetch PC
- next_imemaddr  out  32  PC loaded at the next edge (combinational)
- pred_taken  out  1  current fetch PC predicted taken
- pred_target  out  32  predicted target when pred_taken, else imemaddr+4

## Operation
- Lookup from imemaddr: index = imemaddr[IDX+1:2], tag = imemaddr[31:IDX+2]. Entry fields: valid, tag, target[31:0], type[1:0], ctr[1:0].
- hit = valid && tag match. pred_taken = hit && (type != 00 || ctr[1]).
- next_imemaddr priority: redirect -> redirect_addr; else pc_wait -> imemaddr; else pred_taken -> pred_target; else imemaddr+4. Redirect overrides pc_wait.
- Addition is 32-bit modulo; 32'hFFFFFFFC + 4 wraps to 0.
- Training on upd_valid, index/tag from upd_pc:
  - Hit: ctr saturating +1 if taken, -1 if not (stays at 11 / 00); target, type rewritten when taken.
  - Miss and taken: allocate (overwrite any occupant): valid=1, tag, target, type, ctr=10.
  - Miss and not taken: no write.
- Fetch lookup is read-before-write: a same-cycle update to the fetched index is not seen until the next cycle.
- Reset: imemaddr=PC_INIT, all valid=0, all ctr=01, pred_taken=0, pred_target=PC_INIT+4; reset mid-stall or mid-update discards the update.
- Low bits: imemaddr[1:0] always carries whatever redirect_addr/target supplied; no alignment checks.

## Timing
- PC register updates at each rising CLK; imemaddr is registered; pred_* and next_imemaddr are combinational from imemaddr, table state, and inputs.
- Redirect latency 1: redirect asserted in cycle n gives imemaddr = redirect_addr in cycle n+1.
- Training latency 1: upd_valid in cycle n affects prediction from cycle n+1.
- Fetch "advances" only when pc_wait=0 and redirect=0; RAS side effects happen only on advancing cycles.
- redirect and upd_valid in the same cycle are independent; both take effect.

## Configuration
- PC_BTB_RAS_EN defined: RAS_DEPTH-entry circular return-address stack with pointer and saturating occupancy count.
  - On an advancing cycle with a hit of type 10 (call): push imemaddr+4. When the stack is full, overwrite the oldest entry; the count stays at RAS_DEPTH.
  - On a hit of type 11 (return) with count > 0: pred_target = top of stack, then pop. With count = 0: use the stored BTB target.
  - The stack is not repaired on redirect. Reset empties it.
- PC_BTB_RAS_EN undefined: no stack. Calls and returns predict the stored BTB target, and the RAS_DEPTH parameter is ignored.

## Test plan
- Reset with PC_INIT=32'h100, pc_wait=0 -> imemaddr 100, 104, 108 on consecutive cycles; pred_taken=0.
- pc_wait held 3 cycles at 32'h20, then redirect=1 with addr 32'h400 while pc_wait=1 -> PC holds 20 for the wait cycles; next cycle 400.
- Train upd_pc=32'h40, target 32'h80, type 00, taken -> fetch at 40 predicts 80 (ctr 10). Two not-taken updates -> ctr 00, fetch 40 goes to 44. Three taken updates -> saturates at 11.
- Aliasing with BTB_ENTRIES=16: train 32'h40, then 32'h80 (same index, different tag) -> 40 now misses, 80 hits.
- PC_BTB_RAS_EN, RAS_DEPTH=4: five nested call hits at 10, 20, 30, 40, 50 -> subsequent return hits predict 54, 44, 34, 24, then the BTB-stored target once empty.
- Wrap: redirect to 32'hFFFFFFFC with no hit -> next imemaddr 32'h00000000.
